// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero reported without iterating.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   prem_q;     // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_sr_q;   // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q;     // divisor latched at start
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [2*WIDTH:0] cat_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_d;
  logic [WIDTH-1:0] quo_sr_d;
  logic             last_iter;

  // One restoring step: shift {prem, quo} left, trial-subtract the divisor,
  // keep the difference and set the quotient bit only when it did not borrow.
  always_comb begin
    cat_shift = {prem_q, quo_sr_q} << 1;
    trial     = cat_shift[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
    prem_d    = trial[WIDTH] ? cat_shift[2*WIDTH:WIDTH] : trial;
    quo_sr_d  = cat_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prem_q   <= '0;
      quo_sr_q <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          prem_q   <= prem_d;
          quo_sr_q <= quo_sr_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            quot_q  <= quo_sr_d;
            rem_q   <= prem_d[WIDTH-1:0];
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        // IDLE and DONE accept a new request identically, which is what
        // allows a start in the done cycle to chain operations back-to-back.
        default: begin
          busy_q <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              prem_q   <= '0;
              quo_sr_q <= dividend;
              dvsr_q   <= divisor;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes reference results,
// a negedge monitor pops and compares them on every done pulse.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  e0;
    int unsigned  lat;
  } exp_t;

  exp_t sbq[$];
  int   ntests = 0;
  int   nfail  = 0;

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;
  int unsigned  busy_cnt = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    ntests++;
    nfail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain unsigned division, all-ones quotient on divide-by-zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W;
    end
    e.e0 = 0;
    return e;
  endfunction

  // Monitor: hold checks while busy, full result check on every done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      last_q = '0; last_r = '0; last_dz = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("hold_outputs", {div_by_zero, remainder, quotient}, {last_dz, last_r, last_q});
      end
      if (done) begin
        if (sbq.size() == 0) begin
          report_fail("unexpected_done");
        end else begin
          e = sbq.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.dz);
          check("latency", cyc - e.e0, e.lat);
          check("busy_cycles", busy_cnt, e.lat);
          check("busy_in_done", busy, 1'b0);
        end
        last_q = quotient; last_r = remainder; last_dz = div_by_zero;
        busy_cnt = 0;
      end
    end
  end

  // Drive a request so the next rising edge samples it; returns just after it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start = 1'b1; dividend = a; divisor = b;
    e = model(a, b);
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sbq.push_back(e);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Returns at negedge+1 of the done cycle, so an issue() right after is back-to-back.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) report_fail("done_timeout");
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_div_by_zero", div_by_zero, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    issue(32'd100, 32'd7);             wait_done(); idle_cycle();
    issue(32'hFFFF_FFFF, 32'd1);       wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(); idle_cycle();
    issue(32'd3, 32'd10);              wait_done();
    issue(32'd0, 32'd5);               wait_done(); idle_cycle();
    issue(32'h1234, 32'd0);            wait_done();
    issue(32'd9, 32'd3);               wait_done(); idle_cycle();

    // Stray start and operand churn during RUN must not disturb the result.
    issue(32'd1000, 32'd33);
    repeat (3) idle_cycle();
    start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    idle_cycle();
    start = 1'b0; dividend = 32'd77; divisor = 32'd2;
    wait_done(); idle_cycle();

    // Reset in the middle of an iteration: partial result discarded, no done.
    issue(32'hDEAD_BEEF, 32'd13);
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 4) idle_cycle();

    // Random back-to-back traffic: each start is raised during the done cycle.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0: a = W'($urandom_range(0, 63));
        1: a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'd1;
        2: b = W'($urandom_range(2, 15));
        3: b = '1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b);
      wait_done();
    end
    repeat (W + 4) idle_cycle();
    check("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
